spi_pwm_driver_gen2: RTL

Parametrised successor to the team's 7-channel SPI PWM driver. N_CH independent PWM channels of WIDTH-bit resolution, all sharing one programmable period counter. Channel levels, period and enable mask are written and read over an oversampled mode-0 SPI target. Level, period and enable updates are double-buffered and take effect only at a period boundary, so outputs never glitch; sits directly behind the chip pins.

---
 rtl/spi_pwm_pkg.sv | 19 +
 rtl/spi_pwm_target.sv | 121 ++++++++++++
 rtl/spi_pwm_driver_gen2.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/spi_pwm_pkg.sv
// Shared definitions for the SPI-controlled PWM driver.
// Holds the register address map, the SPI frame geometry and the
// command-byte layout used by the SPI target and the register file.
package spi_pwm_pkg;

    localparam logic [6:0] ADDR_TOP = 7'h70;
    localparam logic [6:0] ADDR_EN  = 7'h71;
    localparam logic [6:0] ADDR_ID  = 7'h7F;

    localparam int FRAME_BITS = 24;
    localparam int CMD_BITS   = 8;

    // First byte of every frame: write flag followed by a 7-bit address.
    typedef struct packed {
        logic       wr;
        logic [6:0] addr;
    } cmd_t;

endpackage

// File: rtl/spi_pwm_target.sv
// Oversampled mode-0 SPI target.
// Synchronises sclk/cs/mosi into clk, detects sclk edges, shifts in an
// 8-bit command plus a 16-bit data word and shifts out read data.
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   sclk, cs, mosi  SPI pins (asynchronous to clk), cs active low
//   miso            SPI data out, forced low while cs is high
//   wr_stb          one-clk pulse when a complete write frame commits
//   addr, wdata     address and data word of the committing write
//   rd_addr         address of the read in progress (valid after bit 8)
//   rdata           register contents for rd_addr, supplied by the top
module spi_pwm_target
    import spi_pwm_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        cs,
    input  logic        mosi,
    output logic        miso,
    output logic        wr_stb,
    output logic [6:0]  addr,
    output logic [15:0] wdata,
    output logic [6:0]  rd_addr,
    input  logic [15:0] rdata
);

    localparam logic [4:0] CMD_CNT   = 5'(CMD_BITS);
    localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_prev;
    logic                   sclk_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   rise;
    logic                   fall;

    logic [4:0]  bit_cnt;
    logic [14:0] shreg;
    cmd_t        cmd_q;
    logic [15:0] tx;
    logic        miso_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_s;
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_prev;
    assign fall   = ~sclk_s & sclk_prev;

    // bit_cnt counts sampled rises in the current frame and saturates at
    // the frame length so trailing bits are ignored. A high cs clears it,
    // which both aborts a partial frame and restarts the next one at bit 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
            shreg   <= '0;
            cmd_q   <= '0;
            tx      <= '0;
            miso_q  <= 1'b0;
            wr_stb  <= 1'b0;
            addr    <= '0;
            wdata   <= '0;
        end else begin
            wr_stb <= 1'b0;
            if (cs_s) begin
                bit_cnt <= '0;
                miso_q  <= 1'b0;
            end else begin
                if (rise && bit_cnt < FRAME_CNT) begin
                    shreg   <= {shreg[13:0], mosi_s};
                    bit_cnt <= bit_cnt + 5'd1;
                    if (bit_cnt == CMD_CNT - 5'd1) begin
                        cmd_q <= {shreg[6:0], mosi_s};
                    end
                    if (bit_cnt == FRAME_CNT - 5'd1 && cmd_q.wr) begin
                        wr_stb <= 1'b1;
                        addr   <= cmd_q.addr;
                        wdata  <= {shreg[14:0], mosi_s};
                    end
                end
                // Read data is captured at the fall following the 8th rise
                // (bit 15 out immediately), then shifted once per fall.
                if (fall) begin
                    if (bit_cnt == CMD_CNT && !cmd_q.wr) begin
                        miso_q <= rdata[15];
                        tx     <= {rdata[14:0], 1'b0};
                    end else if (bit_cnt > CMD_CNT && bit_cnt < FRAME_CNT && !cmd_q.wr) begin
                        miso_q <= tx[15];
                        tx     <= {tx[14:0], 1'b0};
                    end else begin
                        miso_q <= 1'b0;
                    end
                end
            end
        end
    end

    assign rd_addr = cmd_q.addr;
    // Gate with the raw pin so miso drops as soon as the host deselects.
    assign miso    = miso_q & ~cs;

endmodule

// File: rtl/spi_pwm_driver_gen2.sv
// N_CH-channel PWM driver with a shared programmable period, configured
// over SPI. Levels, period top and enable mask are written to staged
// registers and copied to the active set only when the counter wraps.
// Ports:
//   clk, reset   system clock (>= 4x sclk), asynchronous active-high reset
//   sclk, cs     SPI clock (mode 0) and active-low chip select
//   mosi, miso   SPI data in/out, MSB first
//   pwm_out      registered PWM outputs, bit i = channel i
//   period_tick  high on the cycle where the counter wraps top -> 0
module spi_pwm_driver_gen2
    import spi_pwm_pkg::*;
#(
    parameter int N_CH        = 7,
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sclk,
    input  logic            cs,
    input  logic            mosi,
    output logic            miso,
    output logic [N_CH-1:0] pwm_out,
    output logic            period_tick
);

    localparam logic [WIDTH-1:0] TOP_RST = WIDTH'((1 << WIDTH) - 2);
    localparam logic [15:0]      ID_VAL  = {8'(N_CH), 8'(WIDTH)};

    logic        wr_stb;
    logic [6:0]  wr_addr;
    logic [15:0] wdata;
    logic [6:0]  rd_addr;
    logic [15:0] rdata;

    logic [WIDTH-1:0] staged_level [N_CH];
    logic [WIDTH-1:0] active_level [N_CH];
    logic [WIDTH-1:0] staged_top;
    logic [WIDTH-1:0] active_top;
    logic [N_CH-1:0]  staged_en;
    logic [N_CH-1:0]  active_en;
    logic [WIDTH-1:0] counter;
    logic             wrap;
    logic [N_CH-1:0]  pwm_next;
    logic [63:0]      wdata_ext;
    logic [63:0]      en_ext;
    logic             unused_bits;

    spi_pwm_target #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_target (
        .clk     (clk),
        .reset   (reset),
        .sclk    (sclk),
        .cs      (cs),
        .mosi    (mosi),
        .miso    (miso),
        .wr_stb  (wr_stb),
        .addr    (wr_addr),
        .wdata   (wdata),
        .rd_addr (rd_addr),
        .rdata   (rdata)
    );

    assign wdata_ext = {48'd0, wdata};

    always_comb begin
        en_ext = '0;
        en_ext[N_CH-1:0] = staged_en;
    end

    // Data bits above WIDTH (and above N_CH for the mask) are ignored.
    assign unused_bits = ^{wdata_ext, en_ext};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                staged_level[i] <= '0;
            end
            staged_top <= TOP_RST;
            staged_en  <= '1;
        end else if (wr_stb) begin
            for (int i = 0; i < N_CH; i++) begin
                if (wr_addr == 7'(i)) begin
                    staged_level[i] <= wdata[WIDTH-1:0];
                end
            end
            if (wr_addr == ADDR_TOP) begin
                staged_top <= wdata[WIDTH-1:0];
            end
            if (wr_addr == ADDR_EN) begin
                staged_en <= wdata_ext[N_CH-1:0];
            end
        end
    end

    // Reads see the staged set so read-after-write is coherent at once.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (rd_addr == 7'(i)) begin
                rdata = 16'(staged_level[i]);
            end
        end
        if (rd_addr == ADDR_TOP) begin
            rdata = 16'(staged_top);
        end else if (rd_addr == ADDR_EN) begin
            rdata = en_ext[15:0];
        end else if (rd_addr == ADDR_ID) begin
            rdata = ID_VAL;
        end
    end

    assign wrap        = (counter == active_top);
    assign period_tick = wrap;

    // The active set only changes on the wrap edge, so the counter can
    // never sit above a freshly loaded top.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter    <= '0;
            active_top <= TOP_RST;
            active_en  <= '1;
            for (int i = 0; i < N_CH; i++) begin
                active_level[i] <= '0;
            end
        end else if (wrap) begin
            counter      <= '0;
            active_top   <= staged_top;
            active_en    <= staged_en;
            active_level <= staged_level;
        end else begin
            counter <= counter + 1'b1;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign pwm_next[g] = active_en[g] & (counter < active_level[g]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_out <= '0;
        end else begin
            pwm_out <= pwm_next;
        end
    end

endmodule
